// File: rtl/instr_encoder.sv
// Streaming MIPS32 instruction encoder: decoded fields in, machine word plus
// IMEM byte address out, with valid/ready backpressure on both sides.
module instr_encoder (
    input  logic        clk,
    input  logic        rst,
    input  logic        base_load,
    input  logic [31:0] base_addr,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [5:0]  instr_type,
    input  logic [4:0]  rs,
    input  logic [4:0]  rt,
    input  logic [4:0]  rd,
    input  logic [4:0]  sa,
    input  logic [15:0] imm16,
    input  logic [25:0] address,
    input  logic [2:0]  sel,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_word,
    output logic [31:0] out_addr,
    output logic        err,
    output logic [7:0]  err_count,
    output logic [15:0] word_count
);

    // Type codes, shared numbering with the pipeline decoder
    localparam logic [5:0] T_ADD     = 6'd0;
    localparam logic [5:0] T_ADDU    = 6'd1;
    localparam logic [5:0] T_SUB     = 6'd2;
    localparam logic [5:0] T_SUBU    = 6'd3;
    localparam logic [5:0] T_AND     = 6'd4;
    localparam logic [5:0] T_OR      = 6'd5;
    localparam logic [5:0] T_XOR     = 6'd6;
    localparam logic [5:0] T_NOR     = 6'd7;
    localparam logic [5:0] T_SLT     = 6'd8;
    localparam logic [5:0] T_SLTU    = 6'd9;
    localparam logic [5:0] T_SLL     = 6'd10;
    localparam logic [5:0] T_SRL     = 6'd11;
    localparam logic [5:0] T_SRA     = 6'd12;
    localparam logic [5:0] T_SLLV    = 6'd13;
    localparam logic [5:0] T_SRLV    = 6'd14;
    localparam logic [5:0] T_SRAV    = 6'd15;
    localparam logic [5:0] T_JR      = 6'd16;
    localparam logic [5:0] T_ADDI    = 6'd17;
    localparam logic [5:0] T_ADDIU   = 6'd18;
    localparam logic [5:0] T_ANDI    = 6'd19;
    localparam logic [5:0] T_ORI     = 6'd20;
    localparam logic [5:0] T_XORI    = 6'd21;
    localparam logic [5:0] T_LW      = 6'd22;
    localparam logic [5:0] T_SW      = 6'd23;
    localparam logic [5:0] T_BEQ     = 6'd24;
    localparam logic [5:0] T_BNE     = 6'd25;
    localparam logic [5:0] T_SLTI    = 6'd26;
    localparam logic [5:0] T_SLTIU   = 6'd27;
    localparam logic [5:0] T_LUI     = 6'd28;
    localparam logic [5:0] T_J       = 6'd29;
    localparam logic [5:0] T_JAL     = 6'd30;
    localparam logic [5:0] T_JALR    = 6'd31;
    localparam logic [5:0] T_MULT    = 6'd32;
    localparam logic [5:0] T_MULTU   = 6'd33;
    localparam logic [5:0] T_DIV     = 6'd34;
    localparam logic [5:0] T_DIVU    = 6'd35;
    localparam logic [5:0] T_MFLO    = 6'd36;
    localparam logic [5:0] T_MFHI    = 6'd37;
    localparam logic [5:0] T_MTLO    = 6'd38;
    localparam logic [5:0] T_MTHI    = 6'd39;
    localparam logic [5:0] T_TEQ     = 6'd40;
    localparam logic [5:0] T_BREAK   = 6'd41;
    localparam logic [5:0] T_ERET    = 6'd42;
    localparam logic [5:0] T_SYSCALL = 6'd43;
    localparam logic [5:0] T_LB      = 6'd44;
    localparam logic [5:0] T_LBU     = 6'd45;
    localparam logic [5:0] T_LH      = 6'd46;
    localparam logic [5:0] T_LHU     = 6'd47;
    localparam logic [5:0] T_SB      = 6'd48;
    localparam logic [5:0] T_SH      = 6'd49;
    localparam logic [5:0] T_BGEZ    = 6'd50;
    localparam logic [5:0] T_MFC0    = 6'd51;
    localparam logic [5:0] T_MTC0    = 6'd52;
    localparam logic [5:0] T_CLZ     = 6'd53;

    localparam logic [5:0] OP_REGIMM  = 6'b000001;
    localparam logic [5:0] OP_COP0    = 6'b010000;
    localparam logic [5:0] OP_SPECIAL2 = 6'b011100;

    logic [25:0] r_body;
    logic [25:0] i_body;
    logic [31:0] enc_word;
    logic        enc_ok;
    logic [31:0] counter;
    logic        accept;
    logic        handoff;

    // R-type keeps every field verbatim; BREAK/SYSCALL code rides in them too
    assign r_body = {6'b000000, rs, rt, rd, sa};
    assign i_body = {rs, rt, imm16};

    always_comb begin
        enc_ok   = 1'b1;
        enc_word = 32'h0;
        case (instr_type)
            T_ADD:     enc_word = {r_body, 6'h20};
            T_ADDU:    enc_word = {r_body, 6'h21};
            T_SUB:     enc_word = {r_body, 6'h22};
            T_SUBU:    enc_word = {r_body, 6'h23};
            T_AND:     enc_word = {r_body, 6'h24};
            T_OR:      enc_word = {r_body, 6'h25};
            T_XOR:     enc_word = {r_body, 6'h26};
            T_NOR:     enc_word = {r_body, 6'h27};
            T_SLT:     enc_word = {r_body, 6'h2A};
            T_SLTU:    enc_word = {r_body, 6'h2B};
            T_SLL:     enc_word = {r_body, 6'h00};
            T_SRL:     enc_word = {r_body, 6'h02};
            T_SRA:     enc_word = {r_body, 6'h03};
            T_SLLV:    enc_word = {r_body, 6'h04};
            T_SRLV:    enc_word = {r_body, 6'h06};
            T_SRAV:    enc_word = {r_body, 6'h07};
            T_JR:      enc_word = {r_body, 6'h08};
            T_JALR:    enc_word = {r_body, 6'h09};
            T_MULT:    enc_word = {r_body, 6'h18};
            T_MULTU:   enc_word = {r_body, 6'h19};
            T_DIV:     enc_word = {r_body, 6'h1A};
            T_DIVU:    enc_word = {r_body, 6'h1B};
            T_MFHI:    enc_word = {r_body, 6'h10};
            T_MTHI:    enc_word = {r_body, 6'h11};
            T_MFLO:    enc_word = {r_body, 6'h12};
            T_MTLO:    enc_word = {r_body, 6'h13};
            T_TEQ:     enc_word = {r_body, 6'h34};
            T_BREAK:   enc_word = {r_body, 6'h0D};
            T_SYSCALL: enc_word = {r_body, 6'h0C};
            T_ADDI:    enc_word = {6'h08, i_body};
            T_ADDIU:   enc_word = {6'h09, i_body};
            T_ANDI:    enc_word = {6'h0C, i_body};
            T_ORI:     enc_word = {6'h0D, i_body};
            T_XORI:    enc_word = {6'h0E, i_body};
            T_LW:      enc_word = {6'h23, i_body};
            T_SW:      enc_word = {6'h2B, i_body};
            T_BEQ:     enc_word = {6'h04, i_body};
            T_BNE:     enc_word = {6'h05, i_body};
            T_SLTI:    enc_word = {6'h0A, i_body};
            T_SLTIU:   enc_word = {6'h0B, i_body};
            T_LUI:     enc_word = {6'h0F, i_body};
            T_LB:      enc_word = {6'h20, i_body};
            T_LBU:     enc_word = {6'h24, i_body};
            T_LH:      enc_word = {6'h21, i_body};
            T_LHU:     enc_word = {6'h25, i_body};
            T_SB:      enc_word = {6'h28, i_body};
            T_SH:      enc_word = {6'h29, i_body};
            T_J:       enc_word = {6'h02, address};
            T_JAL:     enc_word = {6'h03, address};
            T_BGEZ:    enc_word = {OP_REGIMM, rs, 5'b00001, imm16};
            T_MFC0:    enc_word = {OP_COP0, 5'b00000, rt, rd, 8'h00, sel};
            T_MTC0:    enc_word = {OP_COP0, 5'b00100, rt, rd, 8'h00, sel};
            T_ERET:    enc_word = 32'h4200_0018;
            T_CLZ:     enc_word = {OP_SPECIAL2, rs, rt, rd, 5'b00000, 6'b100000};
            default:   enc_ok   = 1'b0;
        endcase
    end

    // Base reload takes the input slot so counter update and accept never collide
    assign in_ready = !base_load && (!out_valid || out_ready);
    assign accept   = in_valid && in_ready;
    assign handoff  = out_valid && out_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid  <= 1'b0;
            out_word   <= 32'h0;
            out_addr   <= 32'h0;
            counter    <= 32'h0;
            err        <= 1'b0;
            err_count  <= 8'h0;
            word_count <= 16'h0;
        end else begin
            err <= accept && !enc_ok;
            if (accept && enc_ok) begin
                out_word  <= enc_word;
                out_addr  <= counter;
                counter   <= counter + 32'd4;
                out_valid <= 1'b1;
            end else if (handoff) begin
                out_valid <= 1'b0;
            end
            if (base_load)
                counter <= {base_addr[31:2], 2'b00};
            if (handoff)
                word_count <= word_count + 16'd1;
            if (accept && !enc_ok && err_count != 8'hFF)
                err_count <= err_count + 8'd1;
        end
    end

endmodule

// File: tb/tb_instr_encoder.sv
// Self-checking bench for instr_encoder: vector table plus scoreboard of
// expected {word, address} pairs popped as the encoder hands words off.
module tb_instr_encoder;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        base_load = 1'b0;
    logic [31:0] base_addr = 32'h0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [5:0]  instr_type = 6'd0;
    logic [4:0]  rs = 5'd0, rt = 5'd0, rd = 5'd0, sa = 5'd0;
    logic [15:0] imm16 = 16'h0;
    logic [25:0] address = 26'h0;
    logic [2:0]  sel = 3'd0;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_word;
    logic [31:0] out_addr;
    logic        err;
    logic [7:0]  err_count;
    logic [15:0] word_count;

    logic rand_rdy = 1'b0;
    logic rdy_force = 1'b1;
    logic rnd_bit = 1'b1;
    assign out_ready = rand_rdy ? rnd_bit : rdy_force;

    instr_encoder dut (
        .clk(clk), .rst(rst), .base_load(base_load), .base_addr(base_addr),
        .in_valid(in_valid), .in_ready(in_ready), .instr_type(instr_type),
        .rs(rs), .rt(rt), .rd(rd), .sa(sa), .imm16(imm16), .address(address),
        .sel(sel), .out_valid(out_valid), .out_ready(out_ready),
        .out_word(out_word), .out_addr(out_addr), .err(err),
        .err_count(err_count), .word_count(word_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [5:0]  t;
        logic [4:0]  rs, rt, rd, sa;
        logic [15:0] imm;
        logic [25:0] adr;
        logic [2:0]  sel;
        logic [31:0] exp;
        bit          ok;
    } vec_t;

    typedef struct {
        logic [31:0] w;
        logic [31:0] a;
    } exp_t;

    vec_t        vecs[$];
    exp_t        sb[$];
    exp_t        mon_e;
    int          nvec = 0;
    int          nbad = 0;
    int          handoffs = 0;
    logic [31:0] pc = 32'h0;
    int          errs = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nbad++;
            $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic vec_t mk(input logic [5:0] t, input logic [4:0] vrs, input logic [4:0] vrt,
                                input logic [4:0] vrd, input logic [4:0] vsa, input logic [15:0] imm,
                                input logic [25:0] adr, input logic [2:0] vsel,
                                input logic [31:0] exp, input bit ok);
        vec_t v;
        v.t = t; v.rs = vrs; v.rt = vrt; v.rd = vrd; v.sa = vsa;
        v.imm = imm; v.adr = adr; v.sel = vsel; v.exp = exp; v.ok = ok;
        return v;
    endfunction

    initial forever begin
        @(posedge clk);
        #1 rnd_bit = 1'($urandom_range(0, 1));
    end

    // Hand-off happens at the next rising edge whenever both are high here
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                chk("spurious_out", out_word, 32'hxxxx_xxxx);
            end else begin
                mon_e = sb.pop_front();
                chk("word", out_word, mon_e.w);
                chk("addr", out_addr, mon_e.a);
            end
            handoffs++;
        end
    end

    task automatic drive(input vec_t v);
        instr_type = v.t; rs = v.rs; rt = v.rt; rd = v.rd; sa = v.sa;
        imm16 = v.imm; address = v.adr; sel = v.sel;
    endtask

    // Called at posedge+1; returns at posedge+1
    task automatic send(input vec_t v);
        int n = 0;
        drive(v);
        in_valid = 1'b1;
        @(negedge clk);
        while (!in_ready && n < 200) begin
            n++;
            @(negedge clk);
        end
        if (!in_ready) begin
            chk("accept_timeout", 32'(n), 32'd0);
            in_valid = 1'b0;
            @(posedge clk); #1;
            return;
        end
        if (!rand_rdy && rdy_force)
            chk("bubble", 32'(n), 32'd0);
        if (v.ok) begin
            sb.push_back('{v.exp, pc});
            pc = pc + 32'd4;
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        if (!v.ok) begin
            errs = (errs == 255) ? 255 : errs + 1;
            @(negedge clk);
            chk("err_pulse", 32'(err), 32'd1);
            chk("err_count", 32'(err_count), 32'(errs));
            chk("no_out_on_err", 32'(sb.size() == 0 ? out_valid : 1'b0), 32'd0);
            @(posedge clk); #1;
        end
    endtask

    task automatic do_base(input logic [31:0] a);
        base_load = 1'b1;
        base_addr = a;
        @(negedge clk);
        chk("base_blocks_in", 32'(in_ready), 32'd0);
        @(posedge clk); #1;
        base_load = 1'b0;
        pc = {a[31:2], 2'b00};
    endtask

    task automatic drain();
        int n = 0;
        while (sb.size() != 0 && n < 500) begin
            @(posedge clk);
            n++;
        end
        #1;
        chk("drain", 32'(sb.size()), 32'd0);
    endtask

    initial begin
        vec_t        va, vb, bad;
        logic [15:0] wc0;
        logic [31:0] held;

        vecs.push_back(mk(6'd1,  5'd1,  5'd2,  5'd3,  5'd0, 16'h0,    26'h0,       3'd0, 32'h0022_1821, 1'b1)); // ADDU
        vecs.push_back(mk(6'd22, 5'd29, 5'd8,  5'd0,  5'd0, 16'h0004, 26'h0,       3'd0, 32'h8FA8_0004, 1'b1)); // LW
        vecs.push_back(mk(6'd29, 5'd0,  5'd0,  5'd0,  5'd0, 16'h0,    26'h0100000, 3'd0, 32'h0810_0000, 1'b1)); // J
        vecs.push_back(mk(6'd50, 5'd4,  5'd0,  5'd0,  5'd0, 16'hFFFF, 26'h0,       3'd0, 32'h0481_FFFF, 1'b1)); // BGEZ
        vecs.push_back(mk(6'd52, 5'd0,  5'd5,  5'd12, 5'd0, 16'h0,    26'h0,       3'd0, 32'h4085_6000, 1'b1)); // MTC0
        vecs.push_back(mk(6'd42, 5'd7,  5'd9,  5'd11, 5'd3, 16'h1234, 26'h3FFFFFF, 3'd5, 32'h4200_0018, 1'b1)); // ERET
        vecs.push_back(mk(6'd10, 5'd0,  5'd2,  5'd3,  5'd4, 16'h0,    26'h0,       3'd0, 32'h0002_1900, 1'b1)); // SLL
        vecs.push_back(mk(6'd2,  5'd1,  5'd2,  5'd3,  5'd0, 16'h0,    26'h0,       3'd0, 32'h0022_1822, 1'b1)); // SUB
        vecs.push_back(mk(6'd16, 5'd31, 5'd0,  5'd0,  5'd0, 16'h0,    26'h0,       3'd0, 32'h03E0_0008, 1'b1)); // JR
        vecs.push_back(mk(6'd18, 5'd29, 5'd29, 5'd0,  5'd0, 16'hFFF0, 26'h0,       3'd0, 32'h27BD_FFF0, 1'b1)); // ADDIU
        vecs.push_back(mk(6'd60, 5'd1,  5'd1,  5'd1,  5'd1, 16'h1,    26'h1,       3'd1, 32'h0,         1'b0)); // bad
        vecs.push_back(mk(6'd28, 5'd0,  5'd1,  5'd0,  5'd0, 16'h1234, 26'h0,       3'd0, 32'h3C01_1234, 1'b1)); // LUI
        vecs.push_back(mk(6'd30, 5'd0,  5'd0,  5'd0,  5'd0, 16'h0,    26'h3FFFFFF, 3'd0, 32'h0FFF_FFFF, 1'b1)); // JAL
        vecs.push_back(mk(6'd51, 5'd0,  5'd8,  5'd12, 5'd0, 16'h0,    26'h0,       3'd2, 32'h4008_6002, 1'b1)); // MFC0
        vecs.push_back(mk(6'd53, 5'd4,  5'd2,  5'd3,  5'd0, 16'h0,    26'h0,       3'd0, 32'h7082_1820, 1'b1)); // CLZ
        vecs.push_back(mk(6'd43, 5'd0,  5'd0,  5'd0,  5'd0, 16'h0,    26'h0,       3'd0, 32'h0000_000C, 1'b1)); // SYSCALL
        vecs.push_back(mk(6'd41, 5'd1,  5'd0,  5'd0,  5'd0, 16'h0,    26'h0,       3'd0, 32'h0020_000D, 1'b1)); // BREAK
        vecs.push_back(mk(6'd23, 5'd29, 5'd31, 5'd0,  5'd0, 16'h0008, 26'h0,       3'd0, 32'hAFBF_0008, 1'b1)); // SW
        vecs.push_back(mk(6'd54, 5'd0,  5'd0,  5'd0,  5'd0, 16'h0,    26'h0,       3'd0, 32'h0,         1'b0)); // bad
        vecs.push_back(mk(6'd25, 5'd1,  5'd2,  5'd0,  5'd0, 16'hFFFE, 26'h0,       3'd0, 32'h1422_FFFE, 1'b1)); // BNE
        vecs.push_back(mk(6'd36, 5'd0,  5'd0,  5'd2,  5'd0, 16'h0,    26'h0,       3'd0, 32'h0000_1012, 1'b1)); // MFLO
        vecs.push_back(mk(6'd40, 5'd1,  5'd2,  5'd0,  5'd0, 16'h0,    26'h0,       3'd0, 32'h0022_0034, 1'b1)); // TEQ
        vecs.push_back(mk(6'd48, 5'd2,  5'd3,  5'd0,  5'd0, 16'h0001, 26'h0,       3'd0, 32'hA043_0001, 1'b1)); // SB
        vecs.push_back(mk(6'd7,  5'd1,  5'd2,  5'd3,  5'd0, 16'h0,    26'h0,       3'd0, 32'h0022_1827, 1'b1)); // NOR

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_word", out_word, 32'd0);
        chk("rst_out_addr", out_addr, 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_err_count", 32'(err_count), 32'd0);
        chk("rst_word_count", 32'(word_count), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("in_ready_after_rst", 32'(in_ready), 32'd1);
        @(posedge clk); #1;

        // Table pass at full rate, starting at the boot base
        do_base(32'h0040_0000);
        foreach (vecs[i]) send(vecs[i]);
        drain();

        // Same table under random backpressure
        rand_rdy = 1'b1;
        for (int k = 0; k < 2; k++)
            foreach (vecs[i]) send(vecs[i]);
        rand_rdy = 1'b0;
        rdy_force = 1'b1;
        drain();

        // Stall: out_ready low for 3 cycles with a second word waiting
        wc0 = word_count;
        va = vecs[0];
        vb = vecs[1];
        rdy_force = 1'b0;
        send(va);
        drive(vb);
        in_valid = 1'b1;
        held = va.exp;
        repeat (3) begin
            @(negedge clk);
            chk("stall_in_ready", 32'(in_ready), 32'd0);
            chk("stall_word", out_word, held);
        end
        @(posedge clk); #1;
        rdy_force = 1'b1;
        @(negedge clk);
        chk("stall_release", 32'(in_ready), 32'd1);
        sb.push_back('{vb.exp, pc});
        pc = pc + 32'd4;
        @(posedge clk); #1;
        in_valid = 1'b0;
        drain();
        chk("stall_word_count", 32'(word_count), 32'(wc0 + 16'd2));

        // Unencodable type: single pulse, then saturate the counter
        bad = vecs[10];
        send(bad);
        @(negedge clk);
        chk("err_single_cycle", 32'(err), 32'd0);
        @(posedge clk); #1;
        for (int k = 0; k < 299; k++) send(bad);
        chk("err_saturated", 32'(err_count), 32'd255);
        send(vecs[0]);
        drain();

        // Base reload with a word still pending
        rdy_force = 1'b0;
        send(vecs[3]);
        held = out_addr;
        base_load = 1'b1;
        base_addr = 32'h0000_1003;
        @(negedge clk);
        chk("base_in_ready", 32'(in_ready), 32'd0);
        chk("base_pending_addr", out_addr, held);
        chk("base_pending_valid", 32'(out_valid), 32'd1);
        @(posedge clk); #1;
        base_load = 1'b0;
        pc = 32'h0000_1000;
        chk("base_pending_addr2", out_addr, held);
        rdy_force = 1'b1;
        send(vecs[4]);
        send(vecs[5]);
        drain();
        chk("word_count_total", 32'(word_count), 32'(handoffs[15:0]));

        // Reset mid-stream drops the pending word at once
        rdy_force = 1'b0;
        send(vecs[6]);
        #2 rst = 1'b1;
        #1;
        chk("midrst_valid", 32'(out_valid), 32'd0);
        chk("midrst_word_count", 32'(word_count), 32'd0);
        sb.delete();
        pc = 32'h0;
        errs = 0;
        @(posedge clk); #1;
        rst = 1'b0;
        rdy_force = 1'b1;
        send(vecs[0]);
        drain();
        chk("midrst_err_count", 32'(err_count), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: got running want finished");
        $fatal(1, "timeout");
    end

endmodule
